fp16_mul_arb: RTL and testbench

FP16_MUL_ARB -- requirements
Module: fp16_mul_arb

---
 rtl/mamba2_pkg.sv | 32 +++
 rtl/fp16_mult_wrapper.sv | 25 ++
 rtl/fp16_mul_arb.sv | 97 +++++++++
 tb/tb_fp16_mul_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mamba2_pkg.sv
// mamba2_pkg: arbiter FSM encodings, FP16 lane defaults and the FP16 multiply function.
package mamba2_pkg;
  localparam int FP_DW = 16;
  localparam int FP_M_LAT = 6;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE_Q} arb_state_t;
  // Subnormals flush to zero, round to nearest even, canonical quiet NaN.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, hi, rnd;
    logic [21:0] p;
    logic [10:0] m;
    logic signed [7:0] e;
    s = a[15] ^ b[15];
    nan_a = &a[14:10] && |a[9:0];
    nan_b = &b[14:10] && |b[9:0];
    inf_a = &a[14:10] && !(|a[9:0]);
    inf_b = &b[14:10] && !(|b[9:0]);
    zero_a = a[14:10] == 5'd0;
    zero_b = b[14:10] == 5'd0;
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    hi = p[21];
    m = {1'b0, hi ? p[20:11] : p[19:10]};
    rnd = hi ? p[10] && (|p[9:0] || p[11]) : p[9] && (|p[8:0] || p[10]);
    m = m + 11'(rnd);
    e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15
        + $signed({7'b0, hi}) + $signed({7'b0, m[10]});
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return 16'h7E00;
    if (inf_a || inf_b) return {s, 5'h1F, 10'h0};
    if (zero_a || zero_b || e <= 8'sd0) return {s, 15'h0};
    if (e >= 8'sd31) return {s, 5'h1F, 10'h0};
    return {s, e[4:0], m[9:0]};
  endfunction
endpackage

// File: rtl/fp16_mult_wrapper.sv
// fp16_mult_wrapper: FP16 multiplier with result and valid delayed by M_LAT cycles.
module fp16_mult_wrapper import mamba2_pkg::*; #(
  parameter int DW = FP_DW,
  parameter int M_LAT = FP_M_LAT
) (
  input  logic          clk,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          valid_in,
  output logic [DW-1:0] result,
  output logic          valid_out
);
  logic [DW-1:0] res_p [M_LAT];
  logic [M_LAT-1:0] v_p;
  always_ff @(posedge clk) begin
    res_p[0] <= fp16_mul(a, b);
    v_p[0] <= valid_in;
    for (int i = 1; i < M_LAT; i++) begin
      res_p[i] <= res_p[i-1];
      v_p[i] <= v_p[i-1];
    end
  end
  assign result = res_p[M_LAT-1];
  assign valid_out = v_p[M_LAT-1];
endmodule

// File: rtl/fp16_mul_arb.sv
// fp16_mul_arb: round-robin arbiter sharing one FP16 multiplier lane, with drain control.
// Optional FP_MUL_ARB_LOCK_EN adds req_lock so a grantee can keep priority.
module fp16_mul_arb import mamba2_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW = FP_DW,
  parameter int TW = 10,
  parameter int M_LAT = FP_M_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*TW-1:0] req_tag,
`ifdef FP_MUL_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic [TW-1:0]     rsp_tag,
  input  logic              drain_req,
  output logic              drain_done,
  output logic              busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  arb_state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, gid;
  logic gnt, lock, vin_r, mul_v;
  logic [DW-1:0] a_r, b_r;
  logic [M_LAT:0] sh_v;
  logic [IW-1:0] sh_id [M_LAT+1];
  logic [TW-1:0] sh_tag [M_LAT+1];
  // Walk the search order backwards so the first valid requester after ptr wins.
  always_comb begin
    gnt = 1'b0;
    gid = ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt = 1'b1;
        gid = IW'((int'(ptr) + k) % NREQ);
      end
    gnt = gnt && state == ST_RUN && !rst;
`ifdef FP_MUL_ARB_LOCK_EN
    lock = req_lock[gid];
`else
    lock = 1'b0;
`endif
    ptr_nx = !gnt ? ptr : lock ? gid : int'(gid) == NREQ - 1 ? '0 : gid + 1'b1;
    // No acceptances in DRAIN, so only the output stage may still be full.
    state_nx = state == ST_RUN ? (drain_req ? ST_DRAIN : ST_RUN) :
               state == ST_DRAIN ? (|sh_v[M_LAT-1:0] ? ST_DRAIN : ST_IDLE_Q) :
               (drain_req ? ST_IDLE_Q : ST_RUN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_RUN;
      ptr <= '0;
      vin_r <= 1'b0;
      sh_v <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      vin_r <= gnt;
      sh_v <= {sh_v[M_LAT-1:0], gnt};
    end
  always_ff @(posedge clk) begin
    if (gnt) begin
      a_r <= req_a[gid*DW +: DW];
      b_r <= req_b[gid*DW +: DW];
    end
    sh_id[0] <= gid;
    sh_tag[0] <= req_tag[gid*TW +: TW];
    for (int i = 1; i <= M_LAT; i++) begin
      sh_id[i] <= sh_id[i-1];
      sh_tag[i] <= sh_tag[i-1];
    end
  end
  fp16_mult_wrapper #(.DW(DW), .M_LAT(M_LAT)) u_mul (
    .clk(clk), .a(a_r), .b(b_r), .valid_in(vin_r), .result(rsp_data), .valid_out(mul_v)
  );
  assign req_ready = gnt ? NREQ'(1) << gid : '0;
  assign rsp_valid = sh_v[M_LAT] ? NREQ'(1) << sh_id[M_LAT] : '0;
  assign rsp_tag = sh_tag[M_LAT];
  assign busy = |sh_v;
  assign drain_done = state == ST_IDLE_Q;
`ifndef SYNTHESIS
  // The multiplier has no reset; its valid pipe is trusted only once flushed after reset.
  int settle;
  always_ff @(posedge clk or posedge rst)
    if (rst) settle <= 0;
    else if (settle != M_LAT) settle <= settle + 1;
  always_ff @(negedge clk)
    if (!rst && settle == M_LAT)
      assert (mul_v == sh_v[M_LAT]) else $error("multiplier valid_out out of step with shadow pipeline");
`endif
endmodule

// File: tb/tb_fp16_mul_arb.sv
// tb_fp16_mul_arb: directed self-checking bench for fp16_mul_arb (lock test with FP_MUL_ARB_LOCK_EN).
module tb_fp16_mul_arb;
  localparam int NREQ = 4, DW = 16, TW = 10, M_LAT = 6;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
`ifdef FP_MUL_ARB_LOCK_EN
  logic [NREQ-1:0] req_lock;
`endif
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [NREQ*TW-1:0] req_tag;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic drain_req, drain_done, busy;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct { int id; int c; logic [15:0] d; logic [9:0] t; } ev_t;
  ev_t gq[$], rq[$];

  fp16_mul_arb #(.NREQ(NREQ), .DW(DW), .TW(TW), .M_LAT(M_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
`ifdef FP_MUL_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int oh2i(logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (|(req_valid & req_ready)) gq.push_back(ev_t'{oh2i(req_valid & req_ready), cyc, 16'h0, 10'h0});
    if (|rsp_valid) rq.push_back(ev_t'{oh2i(rsp_valid), cyc, rsp_data, rsp_tag});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [9:0] t);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_tag[i*TW +: TW] = t;
  endtask

  logic [15:0] va [10] = '{16'h3C00, 16'hC000, 16'h3800, 16'h3E00, 16'h3C01,
                           16'h7BFF, 16'h7C00, 16'h0000, 16'h3C01, 16'h0000};
  logic [15:0] vb [10] = '{16'h3C00, 16'h4200, 16'h3800, 16'h3E00, 16'h3E00,
                           16'h7BFF, 16'h4000, 16'h7C00, 16'h3C01, 16'h4500};
  logic [15:0] vp [10] = '{16'h3C00, 16'hC600, 16'h3400, 16'h4080, 16'h3E02,
                           16'h7C00, 16'h7C00, 16'h7E00, 16'h3C02, 16'h0000};
  logic [15:0] fa [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
  logic [15:0] fp [4] = '{16'h4000, 16'h4400, 16'h4600, 16'h4800};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, cd;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    drain_req = 1'b0;
`ifdef FP_MUL_ARB_LOCK_EN
    req_lock = '0;
`endif
    step(2);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_drain_done", 32'(drain_done), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    step();
    // single request from requester 2
    gq.delete();
    rq.delete();
    set_req(2, 16'h4000, 16'h4200, 10'd5);
    req_valid = 4'b0100;
    #1 chk("single_ready", 32'(req_ready), 32'h4);
    c0 = cyc;
    step();
    req_valid = '0;
    chk("single_busy", 32'(busy), 32'h1);
    step(8);
    chk("single_count", rq.size(), 1);
    chk("single_id", rq[0].id, 2);
    chk("single_latency", rq[0].c - c0, 7);
    chk("single_data", 32'(rq[0].d), 32'h4600);
    chk("single_tag", 32'(rq[0].t), 32'd5);
    chk("single_idle", 32'(busy), 32'h0);
    // multiplier vectors streamed back-to-back through requester 0
    gq.delete();
    rq.delete();
    for (int i = 0; i < 10; i++) begin
      set_req(0, va[i], vb[i], 10'(i));
      req_valid = 4'b0001;
      step();
    end
    req_valid = '0;
    step(10);
    chk("vec_count", rq.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec_data%0d", i), 32'(rq[i].d), 32'(vp[i]));
      chk($sformatf("vec_tag%0d", i), 32'(rq[i].t), 32'(i));
      chk($sformatf("vec_cycle%0d", i), rq[i].c - gq[i].c, 7);
    end
    // fairness from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    gq.delete();
    rq.delete();
    for (int i = 0; i < 4; i++) set_req(i, fa[i], 16'h4000, 10'(16 + i));
    req_valid = '1;
    step(8);
    req_valid = '0;
    step(10);
    chk("fair_grants", gq.size(), 8);
    chk("fair_rsps", rq.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fair_gnt%0d", k), gq[k].id, k % 4);
      chk($sformatf("fair_rsp%0d", k), rq[k].id, k % 4);
      chk($sformatf("fair_data%0d", k), 32'(rq[k].d), 32'(fp[k % 4]));
      chk($sformatf("fair_tag%0d", k), 32'(rq[k].t), 32'(16 + k % 4));
      chk($sformatf("fair_b2b%0d", k), rq[k].c - rq[0].c, k);
    end
    // drain with three ops in flight
    gq.delete();
    rq.delete();
    set_req(0, 16'h4000, 16'h4000, 10'd7);
    req_valid = 4'b0001;
    step(3);
    drain_req = 1'b1;
    #1 chk("drain_last_accept", 32'(req_ready), 32'h1);
    step();
    chk("drain_blocked", 32'(req_ready), 32'h0);
    chk("drain_busy", 32'(busy), 32'h1);
    chk("drain_not_done", 32'(drain_done), 32'h0);
    for (int i = 0; i < 20 && !drain_done; i++) step();
    cd = cyc;
    chk("drain_done", 32'(drain_done), 32'h1);
    chk("drain_idle", 32'(busy), 32'h0);
    chk("drain_accepts", gq.size(), 4);
    chk("drain_rsps", rq.size(), 4);
    chk("drain_done_timing", cd - rq[rq.size() - 1].c, 1);
    chk("drain_data", 32'(rq[3].d), 32'h4400);
    chk("idle_q_blocked", 32'(req_ready), 32'h0);
    drain_req = 1'b0;
    step();
    #1 chk("resume_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    step(10);
    // reset with five ops in flight, ptr left at 2
    set_req(1, 16'h3C00, 16'h3C00, 10'd9);
    req_valid = 4'b0010;
    step(5);
    req_valid = '0;
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #3 rst = 1'b1;
    #1 chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();
    rq.delete();
    rst = 1'b0;
    step(10);
    chk("rst_no_rsp", rq.size(), 0);
    req_valid = '1;
    #1 chk("rst_ptr", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step(10);
`ifdef FP_MUL_ARB_LOCK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b0001;
    step();
    gq.delete();
    req_valid = '1;
    req_lock = 4'b0010;
    step(4);
    req_lock = '0;
    req_valid = 4'b1101;
    step(3);
    req_valid = '0;
    step(10);
    chk("lock_count", gq.size(), 7);
    for (int k = 0; k < 7; k++) chk($sformatf("lock_gnt%0d", k), gq[k].id, k < 4 ? 1 : (k - 2) % 4);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
